// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multicycle ARM-subset processor: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and write requests.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_control,
    output logic [1:0] result_src,
    output logic [1:0] flag_w,
    output logic       pcs,
    output logic       reg_w,
    output logic       mem_w,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // Data-processing cmd decode, packed as {legal, cmp, arith, alu_control[1:0]}.
    function automatic logic [4:0] alu_decode(input logic [3:0] cmd);
        logic [4:0] res;
        case (cmd)
            4'b0100: res = {1'b1, 1'b0, 1'b1, 2'b00};
            4'b0010: res = {1'b1, 1'b0, 1'b1, 2'b01};
            4'b1010: res = {1'b1, 1'b1, 1'b1, 2'b01};
            4'b0000: res = {1'b1, 1'b0, 1'b0, 2'b10};
            4'b1100: res = {1'b1, 1'b0, 1'b0, 2'b11};
            default: res = {1'b0, 1'b0, 1'b0, 2'b00};
        endcase
        return res;
    endfunction

    state_t     state_r;
    state_t     next_s;
    logic [4:0] dec_s;
    logic       legal_s;
    logic       cmp_s;
    logic       arith_s;
    logic       rd_pc_s;

    assign dec_s   = alu_decode(funct[4:1]);
    assign legal_s = dec_s[4];
    assign cmp_s   = dec_s[3];
    assign arith_s = dec_s[2];
    assign rd_pc_s = (rd == 4'd15);
    assign state   = state_r;

    // State register; reset forces FETCH without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state selection and per-state datapath controls, all from state plus inputs.
    always_comb begin
        next_s      = S_FETCH;
        ir_write    = 1'b0;
        next_pc     = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 2'b00;
        result_src  = 2'b00;
        flag_w      = 2'b00;
        pcs         = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        illegal     = 1'b0;
        instr_done  = 1'b0;
        case (state_r)
            S_FETCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    next_pc  = 1'b1;
                    next_s   = S_DECODE;
                end else begin
                    next_s   = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b00:   next_s = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   next_s = S_MEMADR;
                    2'b10:   next_s = S_BRANCH;
                    default: begin
                        next_s     = S_FETCH;
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                next_s    = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                next_s  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                pcs        = rd_pc_s;
                instr_done = 1'b1;
                next_s     = S_FETCH;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_s     = S_FETCH;
                end else begin
                    next_s     = S_MEMWR;
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                alu_src_b   = (state_r == S_EXECUTEI) ? 2'b01 : 2'b00;
                alu_control = dec_s[1:0];
                illegal     = ~legal_s;
                // CMP always updates every flag; otherwise S gates NZ and arith ops add CV.
                if (cmp_s) begin
                    flag_w = 2'b11;
                end else begin
                    flag_w = {funct[0], funct[0] & arith_s};
                end
                next_s = S_ALUWB;
            end
            S_ALUWB: begin
                alu_control = dec_s[1:0];
                reg_w       = ~cmp_s;
                pcs         = rd_pc_s & ~cmp_s;
                instr_done  = 1'b1;
                next_s      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pcs        = 1'b1;
                instr_done = 1'b1;
                next_s     = S_FETCH;
            end
            default: next_s = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class state by state
// and compares outputs against hand-derived values.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       mem_ready;
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] result_src;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       illegal;
    logic       instr_done;
    logic [3:0] state;

    int checks = 0;
    int fails  = 0;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .rd(rd), .mem_ready(mem_ready),
        .ir_write(ir_write), .next_pc(next_pc), .adr_src(adr_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .result_src(result_src), .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w),
        .mem_w(mem_w), .illegal(illegal), .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst = 1'b0; mem_ready = 1'b0; op = 2'b00; funct = 6'b000000; rd = 4'd0;
        #1;
        checks++; if (state !== 4'd0) begin fails++; $display("FAIL rst_state got %0d want 0", state); end
        checks++; if (alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || result_src !== 2'b10 || alu_control !== 2'b00) begin fails++; $display("FAIL rst_sel got a=%b b=%b r=%b c=%b want 01 10 10 00", alu_src_a, alu_src_b, result_src, alu_control); end
        checks++; if ({ir_write, next_pc, adr_src, flag_w, pcs, reg_w, mem_w, illegal, instr_done} !== 10'd0) begin fails++; $display("FAIL rst_zero got %b want 0", {ir_write, next_pc, adr_src, flag_w, pcs, reg_w, mem_w, illegal, instr_done}); end
        mem_ready = 1'b1; #1;
        checks++; if (ir_write !== 1'b1 || next_pc !== 1'b1) begin fails++; $display("FAIL rst_irw got %b%b want 11", ir_write, next_pc); end
        @(negedge clk); mem_ready = 1'b0; rst = 1'b1;
    endtask

    task automatic test_add_reg;
        @(negedge clk); op = 2'b00; funct = 6'b001001; rd = 4'd3; mem_ready = 1'b1; #1;
        checks++; if (state !== 4'd0 || ir_write !== 1'b1) begin fails++; $display("FAIL add_fetch got st=%0d irw=%b want 0 1", state, ir_write); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd1) begin fails++; $display("FAIL add_decode got %0d want 1", state); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd6 || alu_control !== 2'b00 || flag_w !== 2'b11 || alu_src_b !== 2'b00) begin fails++; $display("FAIL add_exec got st=%0d c=%b f=%b b=%b want 6 00 11 00", state, alu_control, flag_w, alu_src_b); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd8 || reg_w !== 1'b1 || pcs !== 1'b0 || instr_done !== 1'b1) begin fails++; $display("FAIL add_wb got st=%0d rw=%b pcs=%b done=%b want 8 1 0 1", state, reg_w, pcs, instr_done); end
    endtask

    task automatic test_cmp_imm;
        @(negedge clk); op = 2'b00; funct = 6'b110101; rd = 4'd15; mem_ready = 1'b1; #1;
        checks++; if (state !== 4'd0) begin fails++; $display("FAIL cmp_fetch got %0d want 0", state); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd1) begin fails++; $display("FAIL cmp_decode got %0d want 1", state); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd7 || alu_control !== 2'b01 || flag_w !== 2'b11 || alu_src_b !== 2'b01) begin fails++; $display("FAIL cmp_exec got st=%0d c=%b f=%b b=%b want 7 01 11 01", state, alu_control, flag_w, alu_src_b); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd8 || reg_w !== 1'b0 || pcs !== 1'b0 || instr_done !== 1'b1) begin fails++; $display("FAIL cmp_wb got st=%0d rw=%b pcs=%b done=%b want 8 0 0 1", state, reg_w, pcs, instr_done); end
    endtask

    task automatic test_alu_table;
        logic [5:0] t_funct [6] = '{6'b001000, 6'b000101, 6'b000001, 6'b011001, 6'b000011, 6'b010100};
        logic [1:0] t_alu   [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        logic [1:0] t_flag  [6] = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11};
        logic       t_ill   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       t_wr    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); op = 2'b00; funct = t_funct[i]; rd = 4'd15; mem_ready = 1'b1;
            @(negedge clk); mem_ready = 1'b0;
            @(negedge clk); #1;
            checks++; if (state !== 4'd6 || alu_control !== t_alu[i] || flag_w !== t_flag[i] || illegal !== t_ill[i]) begin fails++; $display("FAIL tbl_exec[%0d] got st=%0d c=%b f=%b ill=%b want 6 %b %b %b", i, state, alu_control, flag_w, illegal, t_alu[i], t_flag[i], t_ill[i]); end
            @(negedge clk); #1;
            checks++; if (state !== 4'd8 || reg_w !== t_wr[i] || pcs !== t_wr[i] || instr_done !== 1'b1 || illegal !== 1'b0) begin fails++; $display("FAIL tbl_wb[%0d] got st=%0d rw=%b pcs=%b done=%b ill=%b want 8 %b %b 1 0", i, state, reg_w, pcs, instr_done, illegal, t_wr[i], t_wr[i]); end
        end
    endtask

    task automatic test_ldr_wait;
        int cyc = 0;
        @(negedge clk); op = 2'b01; funct = 6'b000001; rd = 4'd15; mem_ready = 1'b1; cyc++; #1;
        checks++; if (state !== 4'd0) begin fails++; $display("FAIL ldr_fetch got %0d want 0", state); end
        @(negedge clk); cyc++; #1;
        checks++; if (state !== 4'd1) begin fails++; $display("FAIL ldr_decode got %0d want 1", state); end
        @(negedge clk); cyc++; #1;
        checks++; if (state !== 4'd2 || alu_src_a !== 2'b00 || alu_src_b !== 2'b01) begin fails++; $display("FAIL ldr_memadr got st=%0d a=%b b=%b want 2 00 01", state, alu_src_a, alu_src_b); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ready = (i == 2); cyc++; #1;
            checks++; if (state !== 4'd3 || adr_src !== 1'b1 || reg_w !== 1'b0) begin fails++; $display("FAIL ldr_memrd[%0d] got st=%0d adr=%b rw=%b want 3 1 0", i, state, adr_src, reg_w); end
        end
        @(negedge clk); cyc++; #1;
        checks++; if (state !== 4'd4 || reg_w !== 1'b1 || pcs !== 1'b1 || result_src !== 2'b01 || instr_done !== 1'b1) begin fails++; $display("FAIL ldr_memwb got st=%0d rw=%b pcs=%b rs=%b done=%b want 4 1 1 01 1", state, reg_w, pcs, result_src, instr_done); end
        checks++; if (cyc !== 7) begin fails++; $display("FAIL ldr_latency got %0d want 7", cyc); end
    endtask

    task automatic test_str_branch;
        @(negedge clk); op = 2'b01; funct = 6'b000000; rd = 4'd2; mem_ready = 1'b1; #1;
        checks++; if (state !== 4'd0 || mem_w !== 1'b0) begin fails++; $display("FAIL str_fetch got st=%0d mw=%b want 0 0", state, mem_w); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd1 || mem_w !== 1'b0) begin fails++; $display("FAIL str_decode got st=%0d mw=%b want 1 0", state, mem_w); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd2 || mem_w !== 1'b0 || adr_src !== 1'b0) begin fails++; $display("FAIL str_memadr got st=%0d mw=%b adr=%b want 2 0 0", state, mem_w, adr_src); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd5 || mem_w !== 1'b1 || adr_src !== 1'b1 || instr_done !== 1'b1 || reg_w !== 1'b0) begin fails++; $display("FAIL str_memwr got st=%0d mw=%b adr=%b done=%b rw=%b want 5 1 1 1 0", state, mem_w, adr_src, instr_done, reg_w); end
        @(negedge clk); op = 2'b10; #1;
        checks++; if (state !== 4'd0 || mem_w !== 1'b0) begin fails++; $display("FAIL b_fetch got st=%0d mw=%b want 0 0", state, mem_w); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd1 || pcs !== 1'b0) begin fails++; $display("FAIL b_decode got st=%0d pcs=%b want 1 0", state, pcs); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd9 || pcs !== 1'b1 || alu_src_a !== 2'b00 || alu_src_b !== 2'b01 || result_src !== 2'b10 || instr_done !== 1'b1) begin fails++; $display("FAIL b_branch got st=%0d pcs=%b a=%b b=%b rs=%b done=%b want 9 1 00 01 10 1", state, pcs, alu_src_a, alu_src_b, result_src, instr_done); end
    endtask

    task automatic test_fetch_stall_illegal;
        @(negedge clk); op = 2'b11; funct = 6'b000000; rd = 4'd0; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++; if (state !== 4'd0 || ir_write !== 1'b0 || next_pc !== 1'b0) begin fails++; $display("FAIL stall[%0d] got st=%0d irw=%b npc=%b want 0 0 0", i, state, ir_write, next_pc); end
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        checks++; if (state !== 4'd0 || ir_write !== 1'b1) begin fails++; $display("FAIL stall_end got st=%0d irw=%b want 0 1", state, ir_write); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd1 || illegal !== 1'b1 || instr_done !== 1'b1 || ir_write !== 1'b0) begin fails++; $display("FAIL ill_decode got st=%0d ill=%b done=%b irw=%b want 1 1 1 0", state, illegal, instr_done, ir_write); end
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd0 || illegal !== 1'b0 || instr_done !== 1'b0) begin fails++; $display("FAIL ill_back got st=%0d ill=%b done=%b want 0 0 0", state, illegal, instr_done); end
    endtask

    task automatic test_reset_midinstr;
        @(negedge clk); op = 2'b01; funct = 6'b000000; rd = 4'd1; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++; if (state !== 4'd5 || mem_w !== 1'b1 || instr_done !== 1'b0) begin fails++; $display("FAIL mid_wait got st=%0d mw=%b done=%b want 5 1 0", state, mem_w, instr_done); end
        #2; rst = 1'b0; mem_ready = 1'b1; #1;
        checks++; if (state !== 4'd0 || mem_w !== 1'b0 || ir_write !== 1'b1) begin fails++; $display("FAIL mid_reset got st=%0d mw=%b irw=%b want 0 0 1", state, mem_w, ir_write); end
        @(negedge clk); rst = 1'b1; mem_ready = 1'b1; #1;
        checks++; if (state !== 4'd0) begin fails++; $display("FAIL mid_release got %0d want 0", state); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd1) begin fails++; $display("FAIL mid_refetch got %0d want 1", state); end
    endtask

    initial begin
        clk = 1'b0;
        test_reset();
        test_add_reg();
        test_cmp_imm();
        test_alu_table();
        test_ldr_wait();
        test_str_branch();
        test_fetch_stall_illegal();
        test_reset_midinstr();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
